// File: rtl/vram_arbiter.sv
// Three-way arbiter (display > CPU/blitter) for one port of the video SRAM.
// Define VRAM_ARB_ROUND_ROBIN_EN to alternate CPU and blitter; otherwise the CPU has fixed priority.
module vram_arbiter #(
   parameter int D_WIDTH      = 8,
   parameter int A_WIDTH      = 15,
   parameter int STARVE_LIMIT = 15
) (
   input  logic               clk,
   input  logic               rst_async,
   input  logic               disp_req,
   input  logic [A_WIDTH-1:0] disp_addr,
   output logic               disp_gnt,
   output logic               disp_rvalid,
   output logic [D_WIDTH-1:0] disp_rdata,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [A_WIDTH-1:0] cpu_addr,
   input  logic [D_WIDTH-1:0] cpu_wdata,
   output logic               cpu_gnt,
   output logic               cpu_rvalid,
   output logic [D_WIDTH-1:0] cpu_rdata,
   input  logic               blt_req,
   input  logic               blt_we,
   input  logic [A_WIDTH-1:0] blt_addr,
   input  logic [D_WIDTH-1:0] blt_wdata,
   output logic               blt_gnt,
   output logic               blt_rvalid,
   output logic [D_WIDTH-1:0] blt_rdata,
   output logic [A_WIDTH-1:0] sram_addr,
   output logic               sram_we,
   output logic [D_WIDTH-1:0] sram_wdata,
   input  logic [D_WIDTH-1:0] sram_rdata
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DISP = 2'd1;
   localparam logic [1:0] OWN_CPU  = 2'd2;
   localparam logic [1:0] OWN_BLT  = 2'd3;
   localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

   logic [7:0]         r_starve_cnt;
   logic [1:0]         r_owner;
   logic [D_WIDTH-1:0] r_disp_hold;
   logic [D_WIDTH-1:0] r_cpu_hold;
   logic [D_WIDTH-1:0] r_blt_hold;
   logic               w_other_req;
   logic               w_force;
   logic               w_cpu_pick;
   logic [1:0]         w_owner_nxt;

   assign w_other_req = cpu_req | blt_req;
   assign w_force     = (r_starve_cnt == LIMIT) && w_other_req;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
   // Pointer value 0 prefers the CPU, 1 prefers the blitter.
   logic r_rr_ptr;

   assign w_cpu_pick = cpu_req && (!blt_req || (r_rr_ptr == 1'b0));

   // Round-robin pointer: hand preference to the requester that did not just win.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_rr_ptr <= 1'b0;
      end else if (cpu_gnt) begin
         r_rr_ptr <= 1'b1;
      end else if (blt_gnt) begin
         r_rr_ptr <= 1'b0;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end
`else
   assign w_cpu_pick = cpu_req;
`endif

   // Grant selection and SRAM port mux; grants are forced low while in reset.
   always_comb begin
      disp_gnt   = 1'b0;
      cpu_gnt    = 1'b0;
      blt_gnt    = 1'b0;
      sram_addr  = '0;
      sram_we    = 1'b0;
      sram_wdata = '0;
      if (rst_async) begin
         disp_gnt = 1'b0;
      end else if (disp_req && !w_force) begin
         disp_gnt  = 1'b1;
         sram_addr = disp_addr;
      end else if (w_cpu_pick) begin
         cpu_gnt    = 1'b1;
         sram_addr  = cpu_addr;
         sram_we    = cpu_we;
         sram_wdata = cpu_wdata;
      end else if (blt_req) begin
         blt_gnt    = 1'b1;
         sram_addr  = blt_addr;
         sram_we    = blt_we;
         sram_wdata = blt_wdata;
      end else begin
         sram_addr = '0;
      end
   end

   // Owner tag for the read being issued this cycle.
   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (disp_gnt) begin
         w_owner_nxt = OWN_DISP;
      end else if (cpu_gnt && !cpu_we) begin
         w_owner_nxt = OWN_CPU;
      end else if (blt_gnt && !blt_we) begin
         w_owner_nxt = OWN_BLT;
      end else begin
         w_owner_nxt = OWN_NONE;
      end
   end

   // Starvation counter and read-return tag.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_starve_cnt <= 8'd0;
         r_owner      <= OWN_NONE;
      end else begin
         r_owner <= w_owner_nxt;
         if (cpu_gnt || blt_gnt || !w_other_req) begin
            r_starve_cnt <= 8'd0;
         end else if (disp_gnt && (r_starve_cnt != 8'hFF)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end
   end

   // Hold registers keep each requester's last returned word between reads.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_disp_hold <= '0;
         r_cpu_hold  <= '0;
         r_blt_hold  <= '0;
      end else begin
         case (r_owner)
            OWN_DISP: r_disp_hold <= sram_rdata;
            OWN_CPU:  r_cpu_hold  <= sram_rdata;
            OWN_BLT:  r_blt_hold  <= sram_rdata;
            default:  r_disp_hold <= r_disp_hold;
         endcase
      end
   end

   assign disp_rvalid = (r_owner == OWN_DISP);
   assign cpu_rvalid  = (r_owner == OWN_CPU);
   assign blt_rvalid  = (r_owner == OWN_BLT);
   assign disp_rdata  = disp_rvalid ? sram_rdata : r_disp_hold;
   assign cpu_rdata   = cpu_rvalid  ? sram_rdata : r_cpu_hold;
   assign blt_rdata   = blt_rvalid  ? sram_rdata : r_blt_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural registered-read SRAM.
module tb_vram_arbiter;

   localparam int DW = 8;
   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst_async;
   logic          disp_req, disp_gnt, disp_rvalid;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_rdata;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          blt_req, blt_we, blt_gnt, blt_rvalid;
   logic [AW-1:0] blt_addr;
   logic [DW-1:0] blt_wdata, blt_rdata;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic [DW-1:0] sram_wdata, sram_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            exp_cpu;

   vram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .STARVE_LIMIT(15)) dut (
      .clk(clk), .rst_async(rst_async),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
      .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid), .blt_rdata(blt_rdata),
      .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM port model; the 0x0010 preload is rewritten while reset is held.
   always @(posedge clk) begin
      if (rst_async) begin
         mem[15'h0010] <= 8'h5A;
      end else if (sram_we) begin
         mem[sram_addr] <= sram_wdata;
      end
      sram_rdata <= mem[sram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle_all();
      disp_req = 1'b0; cpu_req = 1'b0; blt_req = 1'b0;
      cpu_we = 1'b0; blt_we = 1'b0;
   endtask

   initial begin
      rst_async = 1'b1;
      idle_all();
      disp_addr = 15'h0030; cpu_addr = 15'h0000; blt_addr = 15'h0000;
      cpu_wdata = 8'h00; blt_wdata = 8'h00;
      disp_req = 1'b1;
      repeat (3) next_cycle();
      settle();
      check("rst_disp_gnt", 32'(disp_gnt), 32'd0);
      check("rst_rvalids", 32'({disp_rvalid, cpu_rvalid, blt_rvalid}), 32'd0);
      check("rst_rdatas", 32'({disp_rdata, cpu_rdata, blt_rdata}), 32'd0);

      // Basic CPU read of preloaded word.
      next_cycle();
      rst_async = 1'b0;
      idle_all();
      cpu_req = 1'b1; cpu_addr = 15'h0010;
      settle();
      check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
      check("rd_other_gnt", 32'({disp_gnt, blt_gnt}), 32'd0);
      check("rd_sram_addr", 32'(sram_addr), 32'h10);
      check("rd_sram_we", 32'(sram_we), 32'd0);
      next_cycle();
      idle_all();
      settle();
      check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("rd_cpu_rdata", 32'(cpu_rdata), 32'h5A);
      check("rd_other_rvalid", 32'({disp_rvalid, blt_rvalid}), 32'd0);
      check("idle_sram", 32'({sram_addr, sram_we, sram_wdata}), 32'd0);
      next_cycle();
      settle();
      check("hold_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("hold_cpu_rdata", 32'(cpu_rdata), 32'h5A);

      // Display plus CPU continuously: 15 display grants then one CPU grant.
      next_cycle();
      disp_req = 1'b1; disp_addr = 15'h0030;
      cpu_req = 1'b1; cpu_addr = 15'h0020;
      for (int i = 0; i < 32; i++) begin
         settle();
         exp_cpu = ((i % 16) == 15);
         check($sformatf("starve_disp_gnt[%0d]", i), 32'(disp_gnt), 32'(!exp_cpu));
         check($sformatf("starve_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(exp_cpu));
         check($sformatf("starve_cnt_le15[%0d]", i), 32'(dut.r_starve_cnt <= 8'd15), 32'd1);
         next_cycle();
      end
      idle_all();
      next_cycle();

      // Blitter write then CPU read of the same address in the next cycle.
      blt_req = 1'b1; blt_we = 1'b1; blt_addr = 15'h1234; blt_wdata = 8'hC3;
      settle();
      check("wr_blt_gnt", 32'(blt_gnt), 32'd1);
      check("wr_sram", 32'({sram_addr, sram_we, sram_wdata}), 32'({15'h1234, 1'b1, 8'hC3}));
      next_cycle();
      idle_all();
      cpu_req = 1'b1; cpu_addr = 15'h1234;
      settle();
      check("raw_cpu_gnt", 32'(cpu_gnt), 32'd1);
      check("wr_no_rvalid", 32'(blt_rvalid), 32'd0);
      next_cycle();
      idle_all();
      settle();
      check("raw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("raw_cpu_rdata", 32'(cpu_rdata), 32'hC3);

      // Reset while a CPU read is in flight.
      next_cycle();
      cpu_req = 1'b1; cpu_addr = 15'h0010;
      settle();
      check("mid_cpu_gnt", 32'(cpu_gnt), 32'd1);
      next_cycle();
      rst_async = 1'b1;
      disp_req = 1'b1;
      settle();
      check("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
      check("mid_rst_gnts", 32'({disp_gnt, cpu_gnt, blt_gnt}), 32'd0);
      next_cycle();
      rst_async = 1'b0;
      idle_all();
      settle();
      check("post_rst_starve", 32'(dut.r_starve_cnt), 32'd0);
      check("post_rst_rvalids", 32'({disp_rvalid, cpu_rvalid, blt_rvalid}), 32'd0);

      // CPU and blitter contending without display traffic.
      next_cycle();
      cpu_req = 1'b1; cpu_addr = 15'h0010;
      blt_req = 1'b1; blt_addr = 15'h1234;
      for (int i = 0; i < 4; i++) begin
         settle();
`ifdef VRAM_ARB_ROUND_ROBIN_EN
         exp_cpu = ((i % 2) == 0);
`else
         exp_cpu = 1'b1;
`endif
         check($sformatf("cb_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(exp_cpu));
         check($sformatf("cb_blt_gnt[%0d]", i), 32'(blt_gnt), 32'(!exp_cpu));
         next_cycle();
      end

      // Blitter-only read returns data on the blitter channel.
      idle_all();
      blt_req = 1'b1; blt_addr = 15'h1234;
      settle();
      check("bl_gnt", 32'(blt_gnt), 32'd1);
      next_cycle();
      idle_all();
      settle();
      check("bl_rvalid", 32'(blt_rvalid), 32'd1);
      check("bl_rdata", 32'(blt_rdata), 32'hC3);
      check("bl_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

      next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
